// File: rtl/sp_types_pkg.sv
// -----------------------------------------------------------------------------
// sp_types_pkg
// Shared types and default configuration for the partial-sum writeback path.
//   wb_state_t : writeback controller state (IDLE, ACTIVE, DONE)
//   psum_row_t : one buffered output row {row index, row data} at the default
//                configuration (N_DEF x DW_DEF)
// -----------------------------------------------------------------------------
package sp_types_pkg;

   localparam int unsigned N_DEF     = 4;
   localparam int unsigned DW_DEF    = 16;
   localparam int unsigned AW_DEF    = 32;
   localparam int unsigned DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [$clog2(N_DEF)-1:0]  row;
      logic [N_DEF*DW_DEF-1:0]   data;
   } psum_row_t;

endpackage

// File: rtl/psum_writeback_if.sv
// -----------------------------------------------------------------------------
// psum_writeback_if
// Valid/ready write channel from the writeback block to scratchpad/memory.
//   wr_valid : request valid (master -> slave)
//   wr_ready : request accepted this cycle (slave -> master)
//   wr_addr  : write byte address (master -> slave)
//   wr_data  : write row data (master -> slave)
// -----------------------------------------------------------------------------
interface psum_writeback_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 16
);
   logic            wr_valid;
   logic            wr_ready;
   logic [AW-1:0]   wr_addr;
   logic [N*DW-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
   modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/psum_wb_fifo.sv
// -----------------------------------------------------------------------------
// psum_wb_fifo
// Synchronous DEPTH-entry FIFO (DEPTH a power of two) with flush.
//   CLK, nrst : clock, asynchronous active-low reset
//   push/din  : write request; accepted when not full, or when full and a pop
//               happens in the same cycle
//   pop/dout  : read request (ignored when empty); dout shows the head entry
//   flush     : clear all entries (has priority over push/pop)
//   full/empty: occupancy flags, derived from registered occupancy only
// -----------------------------------------------------------------------------
module psum_wb_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic         CLK,
   input  logic         nrst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = (cnt == (PW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      cnt <= cnt + (PW+1)'(1);
         else if (do_pop && !do_push) cnt <= cnt - (PW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/psum_writeback.sv
// -----------------------------------------------------------------------------
// psum_writeback
// Collects N output rows of one GEMM tile from the systolic array, buffers them
// and writes each row to base + row_index * (N*DW/8) over a valid/ready port.
//   CLK, nrst          : clock, asynchronous active-low reset
//   gemm_start         : starts one tile (honoured only in IDLE)
//   gemm_base_addr     : byte address of row 0, sampled with gemm_start
//   psumout_en/_row_sel_in/_data : array output row (no backpressure)
//   wb_has_space       : buffer not full
//   wr (master)        : write request channel
//   gemm_complete      : one-cycle pulse after the Nth write is accepted
//   overflow           : sticky, a row was dropped in this tile
//   busy               : controller not IDLE
// -----------------------------------------------------------------------------
module psum_writeback
   import sp_types_pkg::*;
#(
   parameter  int unsigned N     = N_DEF,
   parameter  int unsigned DW    = DW_DEF,
   parameter  int unsigned AW    = AW_DEF,
   parameter  int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned RW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic            CLK,
   input  logic            nrst,
   input  logic            gemm_start,
   input  logic [AW-1:0]   gemm_base_addr,
   input  logic            psumout_en,
   input  logic [RW-1:0]   psumout_row_sel_in,
   input  logic [N*DW-1:0] psumout_data,
   output logic            wb_has_space,
   psum_writeback_if.master wr,
   output logic            gemm_complete,
   output logic            overflow,
   output logic            busy
);

   localparam int unsigned ROW_BYTES = (N * DW) / 8;
   localparam int unsigned CW        = $clog2(N + 1);
   localparam int unsigned FW        = RW + N * DW;

   wb_state_t       state_q, state_d;
   logic [AW-1:0]   base_q;
   logic [CW-1:0]   cnt_q;
   logic            ovf_q;

   logic            fifo_full, fifo_empty;
   logic            push, pop, flush, drop, start_ok;
   logic [FW-1:0]   fifo_din, fifo_dout;
   logic [RW-1:0]   head_row;
   logic [N*DW-1:0] head_data;

   assign start_ok  = (state_q == IDLE) && gemm_start;
   assign push      = (state_q == ACTIVE) && psumout_en;
   assign pop       = wr.wr_valid && wr.wr_ready;
   assign drop      = push && fifo_full && !pop;
   // Leftover rows beyond the Nth are cleared on the DONE -> IDLE edge.
   assign flush     = (state_q == DONE);
   assign fifo_din  = {psumout_row_sel_in, psumout_data};
   assign {head_row, head_data} = fifo_dout;

   psum_wb_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .nrst  (nrst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign wr.wr_valid = (state_q == ACTIVE) && !fifo_empty;
   assign wr.wr_data  = head_data;
   assign wr.wr_addr  = base_q + AW'(head_row) * AW'(ROW_BYTES);
   assign wb_has_space = !fifo_full;
   assign overflow     = ovf_q;

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_ok) begin
            base_q <= gemm_base_addr;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
         end else begin
            if (pop)  cnt_q <= cnt_q + CW'(1);
            if (drop) ovf_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      gemm_complete = 1'b0;
      busy          = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (gemm_start) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (pop && (cnt_q == CW'(N - 1))) state_d = DONE;
         end
         DONE: begin
            gemm_complete = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_psum_writeback.sv
// -----------------------------------------------------------------------------
// tb_psum_writeback
// Directed bench for psum_writeback at N=4, DW=16, AW=32, DEPTH=8.
// Inputs change and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_psum_writeback;

   logic        CLK = 1'b0;
   logic        nrst;
   logic        gemm_start;
   logic [31:0] gemm_base_addr;
   logic        psumout_en;
   logic [1:0]  psumout_row_sel_in;
   logic [63:0] psumout_data;
   logic        wb_has_space;
   logic        gemm_complete;
   logic        overflow;
   logic        busy;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   psum_writeback_if #(.AW(32), .N(4), .DW(16)) wr_bus ();

   psum_writeback #(
      .N     (4),
      .DW    (16),
      .AW    (32),
      .DEPTH (8)
   ) dut (
      .CLK                (CLK),
      .nrst               (nrst),
      .gemm_start         (gemm_start),
      .gemm_base_addr     (gemm_base_addr),
      .psumout_en         (psumout_en),
      .psumout_row_sel_in (psumout_row_sel_in),
      .psumout_data       (psumout_data),
      .wb_has_space       (wb_has_space),
      .wr                 (wr_bus),
      .gemm_complete      (gemm_complete),
      .overflow           (overflow),
      .busy               (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   function automatic logic [63:0] mk(input logic [15:0] tag, input int unsigned r);
      return {tag, tag, tag, 16'(r)};
   endfunction

   task automatic drive_row(input int unsigned r, input logic [63:0] d);
      psumout_en         = 1'b1;
      psumout_row_sel_in = 2'(r % 4);
      psumout_data       = d;
   endtask

   // One tile, wr_ready held high, rows 0..3 on consecutive cycles.
   // With glitch set, a second gemm_start with base 0x2000 arrives mid-tile.
   task automatic run_basic(input logic [31:0] base, input logic [15:0] tag, input bit glitch);
      logic [31:0] ea;
      wr_bus.wr_ready = 1'b1;
      gemm_start      = 1'b1;
      gemm_base_addr  = base;
      tick();
      gemm_start = 1'b0;
      check_eq("start_busy", busy, 1);
      check_eq("start_nowr", wr_bus.wr_valid, 0);
      for (int r = 0; r < 4; r++) begin
         drive_row(r, mk(tag, r));
         if (glitch && r == 1) begin
            gemm_start     = 1'b1;
            gemm_base_addr = 32'h0000_2000;
         end else begin
            gemm_start = 1'b0;
         end
         tick();
         ea = base + 32'(8 * r);
         check_eq("basic_valid", wr_bus.wr_valid, 1);
         check_eq("basic_addr", wr_bus.wr_addr, ea);
         check_eq("basic_data", wr_bus.wr_data, mk(tag, r));
         check_eq("basic_nocmp", gemm_complete, 0);
      end
      gemm_start = 1'b0;
      psumout_en = 1'b0;
      tick();
      check_eq("basic_cmp", gemm_complete, 1);
      check_eq("basic_cmp_nowr", wr_bus.wr_valid, 0);
      tick();
      check_eq("basic_cmp_end", gemm_complete, 0);
      check_eq("basic_idle", busy, 0);
   endtask

   initial begin
      nrst               = 1'b0;
      gemm_start         = 1'b0;
      gemm_base_addr     = '0;
      psumout_en         = 1'b0;
      psumout_row_sel_in = '0;
      psumout_data       = '0;
      wr_bus.wr_ready    = 1'b0;

      // Reset values
      tick();
      tick();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", wr_bus.wr_valid, 0);
      check_eq("rst_space", wb_has_space, 1);
      check_eq("rst_ovf", overflow, 0);
      check_eq("rst_cmp", gemm_complete, 0);
      nrst = 1'b1;
      tick();

      // Rows while IDLE are discarded
      drive_row(0, 64'hDEAD_BEEF_0000_0001);
      tick();
      psumout_en = 1'b0;
      tick();
      check_eq("idle_drop_valid", wr_bus.wr_valid, 0);
      check_eq("idle_drop_space", wb_has_space, 1);
      check_eq("idle_drop_ovf", overflow, 0);
      check_eq("idle_drop_busy", busy, 0);

      // Basic tile at 0x1000
      run_basic(32'h0000_1000, 16'h1100, 1'b0);

      // Backpressure: 10 cycles of wr_ready=0 while 4 rows arrive
      wr_bus.wr_ready = 1'b0;
      gemm_start      = 1'b1;
      gemm_base_addr  = 32'h0000_3000;
      tick();
      gemm_start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c < 4) drive_row(c, mk(16'h3300, c));
         else       psumout_en = 1'b0;
         tick();
         check_eq("hold_valid", wr_bus.wr_valid, 1);
         check_eq("hold_addr", wr_bus.wr_addr, 64'h3000);
         check_eq("hold_data", wr_bus.wr_data, mk(16'h3300, 0));
      end
      check_eq("hold_space", wb_has_space, 1);
      check_eq("hold_ovf", overflow, 0);
      for (int k = 0; k < 4; k++) begin
         check_eq("rel_addr", wr_bus.wr_addr, 64'h3000 + 64'(8 * k));
         check_eq("rel_data", wr_bus.wr_data, mk(16'h3300, k));
         wr_bus.wr_ready = 1'b1;
         tick();
      end
      check_eq("rel_cmp", gemm_complete, 1);
      tick();
      check_eq("rel_idle", busy, 0);

      // Overflow: 9 rows into an 8-deep buffer with wr_ready=0
      gemm_start     = 1'b1;
      gemm_base_addr = 32'h0000_5000;
      tick();
      gemm_start      = 1'b0;
      wr_bus.wr_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive_row(i, mk(16'h4400, i));
         tick();
         if (i == 6) check_eq("ovf_space7", wb_has_space, 1);
         if (i == 7) begin
            check_eq("ovf_space8", wb_has_space, 0);
            check_eq("ovf_not_yet", overflow, 0);
         end
         if (i == 8) begin
            check_eq("ovf_set", overflow, 1);
            check_eq("ovf_space9", wb_has_space, 0);
         end
      end
      psumout_en      = 1'b0;
      wr_bus.wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq("ovf_drain_addr", wr_bus.wr_addr, 64'h5000 + 64'(8 * k));
         tick();
      end
      check_eq("ovf_cmp", gemm_complete, 1);
      check_eq("ovf_sticky", overflow, 1);
      tick();
      check_eq("ovf_flush_valid", wr_bus.wr_valid, 0);
      check_eq("ovf_flush_space", wb_has_space, 1);
      check_eq("ovf_sticky_idle", overflow, 1);

      // Full buffer with simultaneous push and accepted pop
      gemm_start      = 1'b1;
      gemm_base_addr  = 32'h0000_6000;
      wr_bus.wr_ready = 1'b0;
      tick();
      gemm_start = 1'b0;
      check_eq("ovf_cleared", overflow, 0);
      for (int i = 0; i < 8; i++) begin
         drive_row(i, mk(16'h5500, i));
         tick();
      end
      check_eq("pp_full", wb_has_space, 0);
      check_eq("pp_head0", wr_bus.wr_addr, 64'h6000);
      drive_row(8, mk(16'h5500, 8));
      wr_bus.wr_ready = 1'b1;
      tick();
      check_eq("pp_still_full", wb_has_space, 0);
      check_eq("pp_no_ovf", overflow, 0);
      check_eq("pp_head1_addr", wr_bus.wr_addr, 64'h6008);
      check_eq("pp_head1_data", wr_bus.wr_data, mk(16'h5500, 1));
      psumout_en = 1'b0;
      tick();
      tick();
      tick();
      check_eq("pp_cmp", gemm_complete, 1);
      tick();
      check_eq("pp_idle", busy, 0);
      check_eq("pp_flushed", wb_has_space, 1);

      // Asynchronous reset after two of four rows written
      gemm_start      = 1'b1;
      gemm_base_addr  = 32'h0000_1000;
      wr_bus.wr_ready = 1'b1;
      tick();
      gemm_start = 1'b0;
      for (int r = 0; r < 3; r++) begin
         drive_row(r, mk(16'h6600, r));
         tick();
      end
      check_eq("mid_valid", wr_bus.wr_valid, 1);
      check_eq("mid_head2", wr_bus.wr_addr, 64'h1010);
      drive_row(3, mk(16'h6600, 3));
      #2 nrst = 1'b0;
      #1;
      check_eq("arst_busy", busy, 0);
      check_eq("arst_valid", wr_bus.wr_valid, 0);
      check_eq("arst_space", wb_has_space, 1);
      check_eq("arst_cmp", gemm_complete, 0);
      check_eq("arst_ovf", overflow, 0);
      psumout_en = 1'b0;
      tick();
      check_eq("arst_hold", busy, 0);
      nrst = 1'b1;
      tick();
      run_basic(32'h0000_1000, 16'h7700, 1'b0);

      // gemm_start during ACTIVE is ignored
      run_basic(32'h0000_1000, 16'h8800, 1'b1);

      // Address wrap: row 1 of base 0xFFFFFFF8 lands at 0
      run_basic(32'hFFFF_FFF8, 16'h9900, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 Parameter N, default 4: systolic array dimension (rows per GEMM tile, elements per row).
REQ-002 Parameter DW, default 16: partial-sum element width in bits.
REQ-003 Parameter AW, default 32: byte address width.
REQ-004 Parameter DEPTH, default 8: row buffer depth, power of two, >= N.
REQ-005 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-006 nrst  in  1  reset, asynchronous, active-low.
REQ-007 gemm_start  in  1  one-cycle pulse starting collection of one N-row output tile.
REQ-008 gemm_base_addr  in  AW  byte address of output row 0, sampled with gemm_start.
REQ-009 psumout_en  in  1  array output row valid this cycle (no backpressure at source).
REQ-010 psumout_row_sel_in  in  $clog2(N)  row index of psumout_data.
REQ-011 psumout_data  in  N*DW  completed output row.
REQ-012 wb_has_space  out  1  buffer not full; fed back to array issue control.
REQ-013 wr_valid  out  1  write request to scratchpad/memory valid.
REQ-014 wr_ready  in  1  downstream accepts the request this cycle.
REQ-015 wr_addr  out  AW  write byte address.
REQ-016 wr_data  out  N*DW  write row data.
REQ-017 gemm_complete  out  1  one-cycle pulse after the Nth row write is accepted.
REQ-018 overflow  out  1  sticky: a row was dropped.
REQ-019 busy  out  1  state is not IDLE.

Function
REQ-020 States IDLE, ACTIVE, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-021 IDLE + gemm_start: latch base address, clear written-row counter and overflow, enter ACTIVE next cycle; gemm_start outside IDLE is ignored.
REQ-022 In ACTIVE, psumout_en pushes {row index, data} into the FIFO if not full, or if full and a pop occurs in the same cycle.
REQ-023 Push when full with no same-cycle pop: row dropped, overflow set next cycle, held until next accepted gemm_start or reset.
REQ-024 psumout_en in IDLE or DONE: row discarded, no state change, overflow unaffected.
REQ-025 wr_valid = FIFO not empty and state ACTIVE; wr_data/wr_addr taken from FIFO head, stable while wr_valid && !wr_ready.
REQ-026 wr_addr = base + row_index * (N*DW/8), computed modulo 2^AW (wraps silently).
REQ-027 Pop on wr_valid && wr_ready; pushed row appears on wr_valid the cycle after push when FIFO was empty (latency 1).
REQ-028 Each pop increments the written counter; the pop bringing it to N moves state to DONE, where gemm_complete = 1 for that single cycle.
REQ-029 Rows beyond N already buffered when DONE is entered are flushed (FIFO cleared) on entry to IDLE.
REQ-030 Simultaneous push and pop: FIFO occupancy unchanged, pointers both advance, pointers wrap modulo DEPTH.
REQ-031 wb_has_space = occupancy < DEPTH, registered-state derived (no combinational path from psumout_en).
REQ-032 Row indices are not checked for duplicates; order of writes equals order of arrival.

Reset
REQ-033 nrst low: state IDLE, FIFO pointers/occupancy 0, counter 0, base 0, overflow 0, gemm_complete 0, wr_valid 0, busy 0, wb_has_space 1; effect immediate, mid-tile data discarded.

Structure
REQ-034 sp_types_pkg holds wb_state_t (IDLE, ACTIVE, DONE) and psum_row_t (row index + N*DW data); parameter defaults as package constants.
REQ-035 FIFO is one sub-module psum_wb_fifo (synchronous, DEPTH entries, push/pop/full/empty/flush); FSM, counter and address logic stay in psum_writeback.

Verification
REQ-036 Start base 0x1000, rows 0..3 one per cycle, wr_ready=1 -> writes at 0x1000,0x1008,0x1010,0x1018 (N=4,DW=16), gemm_complete one cycle after 4th accept.
REQ-037 wr_ready=0 for 10 cycles while 4 rows arrive -> wr_valid held, head data/addr stable, occupancy 4, no drop; release -> 4 writes in order, then complete.
REQ-038 wr_ready=0, 9 rows pushed with DEPTH=8 -> 9th dropped, overflow=1, wb_has_space=0 after 8th; next gemm_start clears overflow.
REQ-039 FIFO full, push and accepted pop same cycle -> no drop, occupancy stays 8, overflow stays 0.
REQ-040 nrst asserted after 2 of 4 rows written -> all outputs at reset values immediately; fresh start then completes normally.
REQ-041 gemm_start during ACTIVE with new base 0x2000 -> ignored, addresses keep original base; base 0xFFFFFFF8 row 1 -> wr_addr 0x00000000.
